// File: rtl/sim_run_ctrl.sv
// Run controller for the core testbench: sequences the core reset and fetch enable,
// then serves a four-word control window that firmware uses to report exit and
// pass/fail status. A RUN-state watchdog ends runaway runs.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | waiting for start_i; core held in reset
// HOLD    | core reset asserted for RST_HOLD_CYCLES cycles
// WAIT    | core reset released, fetch held off for FETCH_DELAY cycles
// RUN     | fetch enabled, cycle counter running, waiting for a terminating event
// DONE    | run finished; flags frozen until rst_ni
module sim_run_ctrl #(
   parameter logic [31:0] BASE_ADDR       = 32'h2000_0000,
   parameter int unsigned RST_HOLD_CYCLES = 16,
   parameter int unsigned FETCH_DELAY     = 4,
   parameter int unsigned TIMEOUT_CYCLES  = 1000000
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        start_i,
   output logic        core_rst_no,
   output logic        fetch_enable_o,
   input  logic        data_req_i,
   input  logic [31:0] data_addr_i,
   input  logic        data_we_i,
   input  logic [3:0]  data_be_i,
   input  logic [31:0] data_wdata_i,
   output logic        data_gnt_o,
   output logic        data_rvalid_o,
   output logic [31:0] data_rdata_o,
   output logic        tests_passed_o,
   output logic        tests_failed_o,
   output logic        exit_valid_o,
   output logic [31:0] exit_value_o,
   output logic        timeout_o
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HOLD,
      ST_WAIT,
      ST_RUN,
      ST_DONE
   } state_e;

   // Timer loads are terminal-count-at-zero, hence the minus one.
   localparam logic [31:0] HOLD_LOAD = (RST_HOLD_CYCLES == 0) ? 32'd0 : 32'(RST_HOLD_CYCLES - 1);
   localparam logic [31:0] WAIT_LOAD = (FETCH_DELAY == 0) ? 32'd0 : 32'(FETCH_DELAY - 1);
   localparam logic [31:0] WDOG_LAST = (TIMEOUT_CYCLES == 0) ? 32'd0 : 32'(TIMEOUT_CYCLES - 1);
   localparam logic        WDOG_EN   = (TIMEOUT_CYCLES != 0);

   localparam logic [1:0] OFS_EXIT   = 2'd0;
   localparam logic [1:0] OFS_RESULT = 2'd1;
   localparam logic [1:0] OFS_CYCLES = 2'd2;
   localparam logic [1:0] OFS_STATUS = 2'd3;

   state_e      state_q, state_d;
   logic [31:0] tmr_q, tmr_d;
   logic [31:0] cyc_q, cyc_d;
   logic        passed_q, passed_d;
   logic        failed_q, failed_d;
   logic        exit_valid_q, exit_valid_d;
   logic [31:0] exit_value_q, exit_value_d;
   logic        timeout_q, timeout_d;
   logic        rvalid_q;
   logic [31:0] rdata_q, rdata_d;

   logic        hit;
   logic [1:0]  offset;
   logic        wr_exit;
   logic        wr_result;
   logic        wdog_fire;
   logic        in_run;

   // Byte enables and the byte-lane address bits play no part in decode.
   logic        unused_bus;
   assign unused_bus = ^{data_be_i, data_addr_i[1:0]};

   assign hit       = data_req_i & (data_addr_i[31:4] == BASE_ADDR[31:4]);
   assign offset    = data_addr_i[3:2];
   assign wr_exit   = hit & data_we_i & (offset == OFS_EXIT);
   assign wr_result = hit & data_we_i & (offset == OFS_RESULT);
   assign in_run    = (state_q == ST_RUN);
   assign wdog_fire = WDOG_EN & (cyc_q == WDOG_LAST);

   // State, timers and sticky result flags.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= ST_IDLE;
         tmr_q        <= '0;
         cyc_q        <= '0;
         passed_q     <= 1'b0;
         failed_q     <= 1'b0;
         exit_valid_q <= 1'b0;
         exit_value_q <= '0;
         timeout_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         tmr_q        <= tmr_d;
         cyc_q        <= cyc_d;
         passed_q     <= passed_d;
         failed_q     <= failed_d;
         exit_valid_q <= exit_valid_d;
         exit_value_q <= exit_value_d;
         timeout_q    <= timeout_d;
      end
   end

   // Sequencing and terminating-event priority (EXIT > RESULT > watchdog).
   always_comb begin
      state_d      = state_q;
      tmr_d        = tmr_q;
      cyc_d        = cyc_q;
      passed_d     = passed_q;
      failed_d     = failed_q;
      exit_valid_d = exit_valid_q;
      exit_value_d = exit_value_q;
      timeout_d    = timeout_q;
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               state_d = ST_HOLD;
               tmr_d   = HOLD_LOAD;
            end
         end
         ST_HOLD: begin
            if (tmr_q == 32'd0) begin
               if (FETCH_DELAY == 0) begin
                  state_d = ST_RUN;
               end else begin
                  state_d = ST_WAIT;
                  tmr_d   = WAIT_LOAD;
               end
            end else begin
               tmr_d = tmr_q - 32'd1;
            end
         end
         ST_WAIT: begin
            if (tmr_q == 32'd0) begin
               state_d = ST_RUN;
            end else begin
               tmr_d = tmr_q - 32'd1;
            end
         end
         ST_RUN: begin
            if (cyc_q != 32'hFFFF_FFFF) begin
               cyc_d = cyc_q + 32'd1;
            end
            if (wr_exit) begin
               exit_valid_d = 1'b1;
               exit_value_d = data_wdata_i;
               state_d      = ST_DONE;
            end else if (wr_result) begin
               if (data_wdata_i == 32'd1) begin
                  passed_d = 1'b1;
               end else begin
                  failed_d = 1'b1;
               end
               state_d = ST_DONE;
            end else if (wdog_fire) begin
               timeout_d = 1'b1;
               state_d   = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_DONE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Read data sampled at grant, so it reflects state before any same-cycle write.
   always_comb begin
      rdata_d = '0;
      if (hit && !data_we_i) begin
         case (offset)
            OFS_CYCLES: rdata_d = cyc_q;
            OFS_STATUS: rdata_d = {27'b0, timeout_q, exit_valid_q, failed_q, passed_q, in_run};
            default:    rdata_d = '0;
         endcase
      end
   end

   // One-cycle response for every granted request.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
      end else begin
         rvalid_q <= hit;
         rdata_q  <= rdata_d;
      end
   end

   assign core_rst_no    = (state_q == ST_WAIT) | (state_q == ST_RUN) | (state_q == ST_DONE);
   assign fetch_enable_o = in_run;
   assign data_gnt_o     = hit;
   assign data_rvalid_o  = rvalid_q;
   assign data_rdata_o   = rdata_q;
   assign tests_passed_o = passed_q;
   assign tests_failed_o = failed_q;
   assign exit_valid_o   = exit_valid_q;
   assign exit_value_o   = exit_value_q;
   assign timeout_o      = timeout_q;

endmodule

// File: tb/tb_sim_run_ctrl.sv
// Directed bench for sim_run_ctrl with a short watchdog so timeout runs stay small.
module tb_sim_run_ctrl;

   localparam logic [31:0] A_EXIT   = 32'h2000_0000;
   localparam logic [31:0] A_RESULT = 32'h2000_0004;
   localparam logic [31:0] A_CYCLES = 32'h2000_0008;
   localparam logic [31:0] A_STATUS = 32'h2000_000C;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        start_i;
   logic        core_rst_no;
   logic        fetch_enable_o;
   logic        data_req_i;
   logic [31:0] data_addr_i;
   logic        data_we_i;
   logic [3:0]  data_be_i;
   logic [31:0] data_wdata_i;
   logic        data_gnt_o;
   logic        data_rvalid_o;
   logic [31:0] data_rdata_o;
   logic        tests_passed_o;
   logic        tests_failed_o;
   logic        exit_valid_o;
   logic [31:0] exit_value_o;
   logic        timeout_o;

   int n_checks = 0;
   int n_errors = 0;

   sim_run_ctrl #(
      .BASE_ADDR      (32'h2000_0000),
      .RST_HOLD_CYCLES(16),
      .FETCH_DELAY    (4),
      .TIMEOUT_CYCLES (100)
   ) u_dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .start_i       (start_i),
      .core_rst_no   (core_rst_no),
      .fetch_enable_o(fetch_enable_o),
      .data_req_i    (data_req_i),
      .data_addr_i   (data_addr_i),
      .data_we_i     (data_we_i),
      .data_be_i     (data_be_i),
      .data_wdata_i  (data_wdata_i),
      .data_gnt_o    (data_gnt_o),
      .data_rvalid_o (data_rvalid_o),
      .data_rdata_o  (data_rdata_o),
      .tests_passed_o(tests_passed_o),
      .tests_failed_o(tests_failed_o),
      .exit_valid_o  (exit_valid_o),
      .exit_value_o  (exit_value_o),
      .timeout_o     (timeout_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // One bus transfer: grant sampled in the request cycle, response one cycle later.
   task automatic bus(input logic [31:0] addr, input logic we, input logic [31:0] wd,
                      output logic gnt, output logic rv, output logic [31:0] rd);
      data_req_i   = 1'b1;
      data_addr_i  = addr;
      data_we_i    = we;
      data_wdata_i = wd;
      data_be_i    = 4'hF;
      #1;
      gnt = data_gnt_o;
      tick();
      rv = data_rvalid_o;
      rd = data_rdata_o;
      data_req_i = 1'b0;
      data_we_i  = 1'b0;
   endtask

   // Reset, start, and stop at the first RUN cycle (cycle counter still 0).
   task automatic start_run();
      int n;
      rst_ni     = 1'b0;
      start_i    = 1'b0;
      data_req_i = 1'b0;
      tick();
      rst_ni  = 1'b1;
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      n = 0;
      while (!fetch_enable_o && n < 100) begin
         n++;
         tick();
      end
      check_eq("run_reached", {31'b0, fetch_enable_o}, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL sim_timeout: bench did not finish");
      $fatal(1);
   end

   initial begin
      logic        g, v;
      logic [31:0] r;
      int          n;

      rst_ni       = 1'b0;
      start_i      = 1'b0;
      data_req_i   = 1'b0;
      data_addr_i  = '0;
      data_we_i    = 1'b0;
      data_be_i    = '0;
      data_wdata_i = '0;
      #3;
      check_eq("rst_core_rst_no", {31'b0, core_rst_no}, 32'd0);
      check_eq("rst_fetch", {31'b0, fetch_enable_o}, 32'd0);
      check_eq("rst_rvalid", {31'b0, data_rvalid_o}, 32'd0);
      check_eq("rst_rdata", data_rdata_o, 32'd0);
      check_eq("rst_flags", {27'b0, timeout_o, exit_valid_o, tests_failed_o, tests_passed_o, 1'b0}, 32'd0);
      check_eq("rst_exit_value", exit_value_o, 32'd0);

      // Reset release and start sequencing
      tick();
      tick();
      rst_ni  = 1'b1;
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      n = 0;
      while (!core_rst_no && n < 100) begin
         n++;
         tick();
      end
      check_eq("hold_cycles", n, 32'd16);
      n = 0;
      while (!fetch_enable_o && n < 100) begin
         n++;
         tick();
      end
      check_eq("fetch_delay", n, 32'd4);
      check_eq("run_core_rst_no", {31'b0, core_rst_no}, 32'd1);

      // Reads in RUN
      bus(A_CYCLES, 1'b0, 32'd0, g, v, r);
      check_eq("cyc0_gnt", {31'b0, g}, 32'd1);
      check_eq("cyc0_rvalid", {31'b0, v}, 32'd1);
      check_eq("cyc0_rdata", r, 32'd0);
      bus(A_CYCLES, 1'b0, 32'd0, g, v, r);
      check_eq("cyc1_rdata", r, 32'd1);
      tick();
      bus(A_CYCLES, 1'b0, 32'd0, g, v, r);
      check_eq("cyc3_rdata", r, 32'd3);
      bus(A_STATUS, 1'b0, 32'd0, g, v, r);
      check_eq("status_run", r, 32'd1);
      bus(A_EXIT, 1'b0, 32'd0, g, v, r);
      check_eq("exit_read", r, 32'd0);
      check_eq("exit_read_rvalid", {31'b0, v}, 32'd1);
      bus(32'h2000_0010, 1'b0, 32'd0, g, v, r);
      check_eq("miss_gnt", {31'b0, g}, 32'd0);
      check_eq("miss_rvalid", {31'b0, v}, 32'd0);
      check_eq("miss_rdata", r, 32'd0);
      bus(32'h1000_0008, 1'b1, 32'd1, g, v, r);
      check_eq("miss_wr_gnt", {31'b0, g}, 32'd0);
      check_eq("miss_wr_passed", {31'b0, tests_passed_o}, 32'd0);

      // EXIT 0 ends the run
      bus(A_EXIT, 1'b1, 32'd0, g, v, r);
      check_eq("exit0_gnt", {31'b0, g}, 32'd1);
      check_eq("exit0_rvalid", {31'b0, v}, 32'd1);
      check_eq("exit0_valid", {31'b0, exit_valid_o}, 32'd1);
      check_eq("exit0_value", exit_value_o, 32'd0);
      check_eq("exit0_fetch", {31'b0, fetch_enable_o}, 32'd0);
      check_eq("exit0_core_rst_no", {31'b0, core_rst_no}, 32'd1);
      bus(A_STATUS, 1'b0, 32'd0, g, v, r);
      check_eq("status_done_exit", r, 32'd8);
      bus(A_RESULT, 1'b1, 32'd1, g, v, r);
      check_eq("done_wr_gnt", {31'b0, g}, 32'd1);
      check_eq("done_wr_rvalid", {31'b0, v}, 32'd1);
      check_eq("done_wr_passed", {31'b0, tests_passed_o}, 32'd0);
      bus(A_EXIT, 1'b1, 32'd9, g, v, r);
      check_eq("done_wr_exit_value", exit_value_o, 32'd0);

      // EXIT 7
      start_run();
      bus(A_EXIT, 1'b1, 32'd7, g, v, r);
      check_eq("exit7_valid", {31'b0, exit_valid_o}, 32'd1);
      check_eq("exit7_value", exit_value_o, 32'd7);

      // RESULT pass
      start_run();
      check_eq("newrun_exit_clear", {31'b0, exit_valid_o}, 32'd0);
      bus(A_RESULT, 1'b1, 32'd1, g, v, r);
      check_eq("pass_passed", {31'b0, tests_passed_o}, 32'd1);
      check_eq("pass_failed", {31'b0, tests_failed_o}, 32'd0);
      check_eq("pass_fetch", {31'b0, fetch_enable_o}, 32'd0);

      // RESULT fail
      start_run();
      bus(A_RESULT, 1'b1, 32'd2, g, v, r);
      check_eq("fail_failed", {31'b0, tests_failed_o}, 32'd1);
      check_eq("fail_passed", {31'b0, tests_passed_o}, 32'd0);

      // Watchdog after 100 RUN cycles
      start_run();
      n = 0;
      while (!timeout_o && n < 200) begin
         n++;
         tick();
      end
      check_eq("wdog_cycles", n, 32'd100);
      check_eq("wdog_fetch", {31'b0, fetch_enable_o}, 32'd0);
      check_eq("wdog_exit_valid", {31'b0, exit_valid_o}, 32'd0);
      bus(A_STATUS, 1'b0, 32'd0, g, v, r);
      check_eq("status_timeout", r, 32'd16);

      // EXIT coinciding with the watchdog cycle wins
      start_run();
      repeat (98) tick();
      bus(A_CYCLES, 1'b0, 32'd0, g, v, r);
      check_eq("cyc98_rdata", r, 32'd98);
      check_eq("pre_wdog_timeout", {31'b0, timeout_o}, 32'd0);
      bus(A_EXIT, 1'b1, 32'd5, g, v, r);
      check_eq("race_exit_valid", {31'b0, exit_valid_o}, 32'd1);
      check_eq("race_exit_value", exit_value_o, 32'd5);
      tick();
      check_eq("race_timeout", {31'b0, timeout_o}, 32'd0);

      // Asynchronous reset clears flags immediately
      #2;
      rst_ni = 1'b0;
      #1;
      check_eq("arst_exit_valid", {31'b0, exit_valid_o}, 32'd0);
      check_eq("arst_exit_value", exit_value_o, 32'd0);
      check_eq("arst_core_rst_no", {31'b0, core_rst_no}, 32'd0);

      // Reset mid-RUN
      start_run();
      repeat (3) tick();
      #2;
      rst_ni = 1'b0;
      #1;
      check_eq("midrun_fetch", {31'b0, fetch_enable_o}, 32'd0);
      check_eq("midrun_core_rst_no", {31'b0, core_rst_no}, 32'd0);
      tick();
      rst_ni = 1'b1;

      // Writes in IDLE are answered but change nothing
      bus(A_EXIT, 1'b1, 32'd9, g, v, r);
      check_eq("idle_wr_gnt", {31'b0, g}, 32'd1);
      check_eq("idle_wr_rvalid", {31'b0, v}, 32'd1);
      check_eq("idle_wr_exit_valid", {31'b0, exit_valid_o}, 32'd0);
      bus(A_RESULT, 1'b1, 32'd1, g, v, r);
      check_eq("idle_wr_passed", {31'b0, tests_passed_o}, 32'd0);
      check_eq("idle_core_rst_no", {31'b0, core_rst_no}, 32'd0);
      tick();
      check_eq("idle_rvalid_drop", {31'b0, data_rvalid_o}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
